// File: rtl/dsp_sample_tx_if.sv
// Core-side sample stream (valid/ready) feeding dsp_sample_tx.
interface dsp_sample_tx_if #(
  parameter int unsigned SAMPLE_W = 16
);
  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dsp_sample_tx.sv
// dsp_sample_tx: FIFO-buffered sample transmitter. Each 16-bit sample leaves as two
// bytes (low first) over a 4-phase strobe/ack pin handshake with an external host.
// Optional even parity on tx_par when DSP_SAMPLE_TX_PARITY_EN is defined.
module dsp_sample_tx #(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  dsp_sample_tx_if.slave              s_if,
  output logic [7:0]                  tx_data,
  output logic                        tx_strb,
  output logic                        tx_hi,
  output logic                        tx_par,
  input  logic                        host_ack,
  output logic [7:0]                  tx_oe,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [7:0]       OE_PINS  = 8'h07;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SEND_LO = 3'd2,
    WAIT_LO = 3'd3,
    SEND_HI = 3'd4,
    WAIT_HI = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                ack_meta, ack_s;
  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0]    level_d;
  logic [SAMPLE_W-1:0] head;
  logic [BYTE_W-1:0]   hold_hi;
  logic                push, pop, has_data;
  logic [BYTE_W-1:0]   tx_data_d;
  logic                tx_strb_d, tx_hi_d;

  assign head     = mem[rd_ptr];
  assign push     = s_if.s_valid & s_if.s_ready;
  assign pop      = (state_q == LOAD);
  assign has_data = (fifo_level != '0);

  // Two-flop synchroniser for the asynchronous host acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= host_ack;
      ack_s    <= ack_meta;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= s_if.s_data;
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    level_d = fifo_level;
    if (push && !pop)      level_d = fifo_level + LVL_W'(1);
    else if (!push && pop) level_d = fifo_level - LVL_W'(1);
  end

  // FIFO pointers, level and registered ready (looks ahead at the next level).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      s_if.s_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level   <= level_d;
      s_if.s_ready <= ena & (level_d < FULL_LVL);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (has_data && ena && !ack_s) state_d = LOAD;
      LOAD:    state_d = SEND_LO;
      SEND_LO: if (ack_s) state_d = WAIT_LO;
      WAIT_LO: if (!ack_s) state_d = SEND_HI;
      SEND_HI: if (ack_s) state_d = WAIT_HI;
      WAIT_HI: if (!ack_s) state_d = (has_data && ena) ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin values for the upcoming state; tx_data only moves when a byte is launched.
  always_comb begin
    tx_data_d = tx_data;
    tx_strb_d = 1'b0;
    tx_hi_d   = tx_hi;
    unique case (state_d)
      SEND_LO: begin
        tx_strb_d = 1'b1;
        tx_hi_d   = 1'b0;
        if (state_q == LOAD) tx_data_d = head[BYTE_W-1:0];
      end
      SEND_HI: begin
        tx_strb_d = 1'b1;
        tx_hi_d   = 1'b1;
        if (state_q == WAIT_LO) tx_data_d = hold_hi;
      end
      default: ;
    endcase
  end

  // Registered pin outputs and the high-byte holding register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_data <= '0;
      tx_strb <= 1'b0;
      tx_hi   <= 1'b0;
      hold_hi <= '0;
      tx_oe   <= '0;
    end else begin
      tx_data <= tx_data_d;
      tx_strb <= tx_strb_d;
      tx_hi   <= tx_hi_d;
      tx_oe   <= OE_PINS;
      if (pop) hold_hi <= head[SAMPLE_W-1:BYTE_W];
    end
  end

`ifdef DSP_SAMPLE_TX_PARITY_EN
  // Even parity registered alongside the byte it covers.
  always_ff @(posedge clk) begin
    if (!rst_n) tx_par <= 1'b0;
    else        tx_par <= ^tx_data_d;
  end
`else
  assign tx_par = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_sample_tx.sv
// Self-checking bench for dsp_sample_tx: host handshake model, byte monitor and
// a sample-to-byte-stream reference model.
module tb_dsp_sample_tx;
  localparam int MAX_WAIT = 400;
`ifdef DSP_SAMPLE_TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  typedef struct packed {
    logic        hi;
    logic        par;
    logic [7:0]  data;
    logic [31:0] cyc;
  } cap_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        host_ack = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_strb, tx_hi, tx_par;
  logic [7:0]  tx_oe;
  logic [2:0]  fifo_level;

  dsp_sample_tx_if sif ();

  int          checks = 0;
  int          failures = 0;
  logic [31:0] cyc = '0;
  bit          host_auto = 1'b0;
  bit          host_force = 1'b0;
  bit          host_rand = 1'b0;
  cap_t        cap_q[$];
  logic [31:0] ack_q[$];
  logic [31:0] rel_q[$];
  logic [31:0] fall_q[$];
  int          stab_err = 0;
  logic [31:0] last_push_cyc = '0;

  dsp_sample_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .s_if       (sif),
    .tx_data    (tx_data),
    .tx_strb    (tx_strb),
    .tx_hi      (tx_hi),
    .tx_par     (tx_par),
    .host_ack   (host_ack),
    .tx_oe      (tx_oe),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 32'd1;
  end

  // Host: raise ack a few clocks after a strobe rises, drop it a few clocks after it falls.
  initial begin : host_model
    int cnt;
    int ack_dly;
    int rel_dly;
    cnt = 0; ack_dly = 2; rel_dly = 2;
    forever begin
      @(negedge clk);
      if (!host_auto) begin
        host_ack = host_force;
        cnt = 0;
      end else if (!host_ack) begin
        if (tx_strb) begin
          cnt++;
          if (cnt >= (host_rand ? ack_dly : 2)) begin
            host_ack = 1'b1; cnt = 0; ack_q.push_back(cyc);
            ack_dly = int'($urandom_range(4, 1));
          end
        end else cnt = 0;
      end else begin
        if (!tx_strb) begin
          cnt++;
          if (cnt >= (host_rand ? rel_dly : 2)) begin
            host_ack = 1'b0; cnt = 0; rel_q.push_back(cyc);
            rel_dly = int'($urandom_range(4, 1));
          end
        end else cnt = 0;
      end
    end
  end

  // Monitor: log every strobe rise and fall, flag data moving under a high strobe.
  initial begin : monitor
    logic       prev_strb;
    logic [7:0] prev_data;
    prev_strb = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (tx_strb && !prev_strb) cap_q.push_back('{hi: tx_hi, par: tx_par, data: tx_data, cyc: cyc});
      if (tx_strb && prev_strb && tx_data !== prev_data) stab_err++;
      if (!tx_strb && prev_strb) fall_q.push_back(cyc);
      prev_strb = tx_strb;
      prev_data = tx_data;
    end
  end

  function automatic logic exp_par(input logic [7:0] b);
    return (^b) & PAR_ON;
  endfunction

  task automatic push_sample(input logic [15:0] d, output bit ok);
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    ok = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      if (sif.s_ready) begin ok = 1'b1; last_push_cyc = cyc + 32'd1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    sif.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sif.s_ready, tx_oe, tx_strb, fifo_level} !== 13'd0) begin
      failures++;
      $display("FAIL reset_hold got s_ready=%b tx_oe=%h tx_strb=%b level=%0d required all zero",
               sif.s_ready, tx_oe, tx_strb, fifo_level);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (tx_strb !== 1'b0 || tx_data !== 8'h00 || fifo_level !== 3'd0 || tx_oe !== 8'h07) begin
        failures++;
        $display("FAIL reset_idle cyc%0d got strb=%b data=%h level=%0d oe=%h required 0,00,0,07",
                 i, tx_strb, tx_data, fifo_level, tx_oe);
      end
    end
  endtask

  task automatic test_single();
    int cb, ab, fb;
    bit ok;
    cb = cap_q.size(); ab = ack_q.size(); fb = fall_q.size();
    host_auto = 1'b1; host_rand = 1'b0;
    push_sample(16'hA53C, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_push got accepted=0 required 1"); end
    for (int i = 0; i < MAX_WAIT && cap_q.size() < cb + 2; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++;
    if (cap_q.size() - cb != 2) begin
      failures++; $display("FAIL single_strobes got %0d required 2", cap_q.size() - cb);
    end
    if (cap_q.size() >= cb + 2 && fall_q.size() > fb && ack_q.size() > ab) begin
      checks++;
      if ({cap_q[cb].hi, cap_q[cb].data} !== {1'b0, 8'h3C}) begin
        failures++; $display("FAIL single_lo got hi=%b data=%h required 0 3C", cap_q[cb].hi, cap_q[cb].data);
      end
      checks++;
      if ({cap_q[cb+1].hi, cap_q[cb+1].data} !== {1'b1, 8'hA5}) begin
        failures++; $display("FAIL single_hi got hi=%b data=%h required 1 A5", cap_q[cb+1].hi, cap_q[cb+1].data);
      end
      checks++;
      if (cap_q[cb].cyc - last_push_cyc !== 32'd2) begin
        failures++; $display("FAIL single_latency got %0d required 2", cap_q[cb].cyc - last_push_cyc);
      end
      checks++;
      if (fall_q[fb] - ack_q[ab] !== 32'd3) begin
        failures++; $display("FAIL single_strb_fall got %0d clk after pin ack required 3", fall_q[fb] - ack_q[ab]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cb, rb;
    bit ok;
    logic [15:0] s0, s1;
    cb = cap_q.size(); rb = rel_q.size();
    s0 = 16'($urandom); s1 = 16'($urandom);
    push_sample(s0, ok);
    push_sample(s1, ok);
    for (int i = 0; i < MAX_WAIT && cap_q.size() < cb + 4; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (cap_q.size() - cb != 4 || rel_q.size() - rb < 2) begin
      failures++; $display("FAIL b2b_count got %0d bytes required 4", cap_q.size() - cb);
    end else begin
      checks++;
      if ({cap_q[cb].data, cap_q[cb+1].data, cap_q[cb+2].data, cap_q[cb+3].data} !==
          {s0[7:0], s0[15:8], s1[7:0], s1[15:8]}) begin
        failures++; $display("FAIL b2b_bytes got %h %h %h %h required %h %h %h %h",
          cap_q[cb].data, cap_q[cb+1].data, cap_q[cb+2].data, cap_q[cb+3].data,
          s0[7:0], s0[15:8], s1[7:0], s1[15:8]);
      end
      checks++;
      if (cap_q[cb+1].cyc - rel_q[rb] !== 32'd3) begin
        failures++; $display("FAIL b2b_hi_latency got %0d required 3", cap_q[cb+1].cyc - rel_q[rb]);
      end
      checks++;
      if (cap_q[cb+2].cyc - rel_q[rb+1] !== 32'd4) begin
        failures++; $display("FAIL b2b_next_lo_latency got %0d required 4", cap_q[cb+2].cyc - rel_q[rb+1]);
      end
    end
  endtask

  task automatic test_fifo_full();
    int cb;
    bit ok;
    logic [8:0] exp_q[$];
    cb = cap_q.size();
    host_auto = 1'b0; host_force = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      push_sample(16'(k), ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL full_push%0d got accepted=0 required 1", k); end
      exp_q.push_back({1'b0, 8'(k)});
      exp_q.push_back({1'b1, 8'h00});
    end
    checks++;
    if (fifo_level !== 3'd4 || sif.s_ready !== 1'b0) begin
      failures++; $display("FAIL full_level got level=%0d s_ready=%b required 4 0", fifo_level, sif.s_ready);
    end
    checks++;
    if ({tx_strb, tx_hi, tx_data} !== {1'b1, 1'b0, 8'h01}) begin
      failures++; $display("FAIL full_first_strobe got strb=%b hi=%b data=%h required 1 0 01", tx_strb, tx_hi, tx_data);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (fifo_level !== 3'd4 || sif.s_ready !== 1'b0) begin
      failures++; $display("FAIL full_stall got level=%0d s_ready=%b required 4 0", fifo_level, sif.s_ready);
    end
    host_auto = 1'b1;
    for (int i = 0; i < MAX_WAIT * 2 && cap_q.size() < cb + 10; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (cap_q.size() - cb != 10) begin
      failures++; $display("FAIL full_count got %0d bytes required 10", cap_q.size() - cb);
    end
    for (int i = 0; i < exp_q.size() && cb + i < cap_q.size(); i++) begin
      checks++;
      if ({cap_q[cb+i].hi, cap_q[cb+i].data} !== exp_q[i]) begin
        failures++; $display("FAIL full_byte%0d got hi=%b data=%h required hi=%b data=%h",
          i, cap_q[cb+i].hi, cap_q[cb+i].data, exp_q[i][8], exp_q[i][7:0]);
      end
    end
  endtask

  task automatic test_ena_drop();
    int cb, ab;
    bit ok;
    cb = cap_q.size(); ab = ack_q.size();
    push_sample(16'h1234, ok);
    push_sample(16'h5678, ok);
    for (int i = 0; i < MAX_WAIT && ack_q.size() <= ab; i++) @(negedge clk);
    ena = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (cap_q.size() - cb != 2) begin
      failures++; $display("FAIL ena_drop_count got %0d bytes required 2", cap_q.size() - cb);
    end else begin
      checks++;
      if ({cap_q[cb].data, cap_q[cb+1].data} !== 16'h3412) begin
        failures++; $display("FAIL ena_drop_bytes got %h %h required 34 12", cap_q[cb].data, cap_q[cb+1].data);
      end
    end
    checks++;
    if (sif.s_ready !== 1'b0 || fifo_level !== 3'd1 || tx_strb !== 1'b0) begin
      failures++; $display("FAIL ena_drop_idle got s_ready=%b level=%0d strb=%b required 0 1 0",
        sif.s_ready, fifo_level, tx_strb);
    end
    ena = 1'b1;
    for (int i = 0; i < MAX_WAIT && cap_q.size() < cb + 4; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (cap_q.size() - cb != 4) begin
      failures++; $display("FAIL ena_resume_count got %0d bytes required 4", cap_q.size() - cb);
    end else begin
      checks++;
      if ({cap_q[cb+2].data, cap_q[cb+3].data} !== 16'h7856) begin
        failures++; $display("FAIL ena_resume_bytes got %h %h required 78 56", cap_q[cb+2].data, cap_q[cb+3].data);
      end
    end
  endtask

  task automatic test_parity();
    int cb;
    bit ok;
    cb = cap_q.size();
    push_sample(16'h0307, ok);
    for (int i = 0; i < MAX_WAIT && cap_q.size() < cb + 2; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (cap_q.size() - cb != 2) begin
      failures++; $display("FAIL parity_count got %0d bytes required 2", cap_q.size() - cb);
    end else begin
      checks++;
      if (cap_q[cb].data !== 8'h07 || cap_q[cb].par !== PAR_ON) begin
        failures++; $display("FAIL parity_lo got data=%h par=%b required 07 %b", cap_q[cb].data, cap_q[cb].par, PAR_ON);
      end
      checks++;
      if (cap_q[cb+1].data !== 8'h03 || cap_q[cb+1].par !== 1'b0) begin
        failures++; $display("FAIL parity_hi got data=%h par=%b required 03 0", cap_q[cb+1].data, cap_q[cb+1].par);
      end
    end
  endtask

  task automatic test_random();
    int cb, se;
    bit ok;
    logic [15:0] smp;
    logic [8:0]  exp_q[$];
    cb = cap_q.size(); se = stab_err;
    host_rand = 1'b1;
    for (int n = 0; n < 20; n++) begin
      smp = 16'($urandom);
      push_sample(smp, ok);
      exp_q.push_back({1'b0, smp[7:0]});
      exp_q.push_back({1'b1, smp[15:8]});
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    for (int i = 0; i < MAX_WAIT * 4 && cap_q.size() < cb + 40; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    host_rand = 1'b0;
    checks++;
    if (cap_q.size() - cb != 40 || fifo_level !== 3'd0) begin
      failures++; $display("FAIL rand_count got %0d bytes level=%0d required 40 0", cap_q.size() - cb, fifo_level);
    end
    for (int i = 0; i < exp_q.size() && cb + i < cap_q.size(); i++) begin
      checks++;
      if ({cap_q[cb+i].hi, cap_q[cb+i].data, cap_q[cb+i].par} !== {exp_q[i], exp_par(exp_q[i][7:0])}) begin
        failures++; $display("FAIL rand_byte%0d got hi=%b data=%h par=%b required hi=%b data=%h par=%b",
          i, cap_q[cb+i].hi, cap_q[cb+i].data, cap_q[cb+i].par,
          exp_q[i][8], exp_q[i][7:0], exp_par(exp_q[i][7:0]));
      end
    end
    checks++;
    if (stab_err != se) begin
      failures++; $display("FAIL rand_data_stable got %0d changes under strobe required 0", stab_err - se);
    end
  endtask

  task automatic test_reset_mid();
    int cb;
    bit ok, found;
    found = 1'b0;
    push_sample(16'hBEEF, ok);
    push_sample(16'hCAFE, ok);
    push_sample(16'hF00D, ok);
    for (int i = 0; i < MAX_WAIT; i++) begin
      if (tx_strb && tx_hi) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found || fifo_level !== 3'd2) begin
      failures++; $display("FAIL rstmid_setup got send_hi=%b level=%0d required 1 2", found, fifo_level);
    end
    rst_n = 1'b0; host_auto = 1'b0; host_force = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_strb !== 1'b0 || fifo_level !== 3'd0 || sif.s_ready !== 1'b0 || tx_oe !== 8'h00) begin
      failures++; $display("FAIL rstmid_abort got strb=%b level=%0d s_ready=%b oe=%h required 0 0 0 00",
        tx_strb, fifo_level, sif.s_ready, tx_oe);
    end
    @(negedge clk);
    rst_n = 1'b1; host_auto = 1'b1;
    cb = cap_q.size();
    repeat (30) @(negedge clk);
    checks++;
    if (cap_q.size() != cb || tx_strb !== 1'b0 || fifo_level !== 3'd0) begin
      failures++; $display("FAIL rstmid_quiet got %0d new strobes level=%0d required 0 0", cap_q.size() - cb, fifo_level);
    end
  endtask

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_ena_drop();
    test_parity();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
